// File: rtl/mux8_32b_arbiter.sv
// Purpose: round-robin arbiter that owns the select of a shared 8:1 x 32-bit mux
//          and gates the mux output onto a common bus while a grant is active.
// Latency: grant/sel registered one cycle after req; bus_valid/bus_data combinational.
// Backpressure: none; owner paces beats with its req bit, ends with last (or timeout).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[7:0], last[7:0] per-requester request and final-beat flag (last used for owner only)
//   d0..d7[31:0]        requester data, feeding mux inputs a..h
//   gnt[7:0], sel[2:0]  registered one-hot grant and matching mux select
//   bus_valid, bus_data beat strobe and gated mux output (0 when no beat)
//   timeout             one-cycle pulse on a forced release
//
// Optional feature: define ARB_TIMEOUT_EN to build the per-grant beat limit (MAX_HOLD).

module mux8_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] f,
    input  logic [31:0] g,
    input  logic [31:0] h,
    input  logic [2:0]  sel,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        unique case (sel)
            3'd0: y = a;
            3'd1: y = b;
            3'd2: y = c;
            3'd3: y = d;
            3'd4: y = e;
            3'd5: y = f;
            3'd6: y = g;
            3'd7: y = h;
            default: y = '0;
        endcase
    end
endmodule

module mux8_32b_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  req,
    input  logic [7:0]  last,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [31:0] d4,
    input  logic [31:0] d5,
    input  logic [31:0] d6,
    input  logic [31:0] d7,
    output logic [7:0]  gnt,
    output logic [2:0]  sel,
    output logic        bus_valid,
    output logic [31:0] bus_data,
    output logic        timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
        $error("MAX_HOLD must be in 2..256");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  gnt_nxt;
    logic [2:0]  sel_nxt;
    logic [2:0]  ptr, ptr_nxt;     // index of the most recent owner
    logic [2:0]  win;
    logic [2:0]  idx;
    logic        found;
    logic        any_req;
    logic        release_now;
    logic        timeout_hit;
    logic [31:0] mux_out;

    mux8_32b u_mux (
        .a   (d0),
        .b   (d1),
        .c   (d2),
        .d   (d3),
        .e   (d4),
        .f   (d5),
        .g   (d6),
        .h   (d7),
        .sel (sel),
        .y   (mux_out)
    );

    assign any_req   = |req;
    assign bus_valid = (state == GRANT) && req[sel];
    assign bus_data  = mux_out & {32{bus_valid}};

    // Search starts just past the last owner and wraps, so the last owner is
    // considered only after every other requester (k == 8 lands on ptr itself).
    always_comb begin
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        sel_nxt     = sel;
        ptr_nxt     = ptr;
        release_now = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 8'b1 << win;
                    sel_nxt   = win;
                    ptr_nxt   = win;
                end
            end
            GRANT: begin
                release_now = !req[sel] || (bus_valid && last[sel]) || timeout_hit;
                if (release_now) begin
                    if (any_req) begin
                        // Covers both hand-over and re-grant of a sole owner.
                        gnt_nxt = 8'b1 << win;
                        sel_nxt = win;
                        ptr_nxt = win;
                    end else begin
                        // sel deliberately keeps its last value.
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= 3'd7;   // requester 0 wins the first search
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [8:0] HOLD_LIM = 9'(MAX_HOLD);

    logic [7:0] beat_cnt, beat_cnt_nxt;
    logic       new_grant;

    // Every grant issue (including a re-grant) restarts the count.
    assign new_grant   = any_req && ((state == IDLE) || release_now);
    // Nine-bit compare so MAX_HOLD = 256 is reachable from an 8-bit count.
    assign timeout_hit = bus_valid && (({1'b0, beat_cnt} + 9'd1) == HOLD_LIM);
    assign timeout     = timeout_hit;

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (new_grant) begin
            beat_cnt_nxt = '0;
        end else if (bus_valid) begin
            beat_cnt_nxt = beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else begin
            beat_cnt <= beat_cnt_nxt;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_32b_arbiter.sv
// Purpose: self-checking bench for mux8_32b_arbiter against a behavioural model.
// Latency: model predicts registered grant one cycle after req, combinational beats.
// Backpressure: stimulus drives req/last freely; model follows the same release rules.

module tb_mux8_32b_arbiter;

    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [7:0]  last;
    logic [31:0] d [8];
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        bus_valid;
    logic [31:0] bus_data;
    logic        timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner index (-1 when idle), last owner, beats in grant.
    int m_owner = -1;
    int m_ptr   = 7;
    int m_sel   = 0;
    int m_cnt   = 0;

    mux8_32b_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .d4        (d[4]),
        .d5        (d[5]),
        .d6        (d[6]),
        .d7        (d[7]),
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 7;
        m_sel   = 0;
        m_cnt   = 0;
    endtask

    // Winner = requester at the smallest forward distance past the last owner.
    function automatic int pick(input logic [7:0] r);
        int best  = -1;
        int bestd = 99;
        for (int i = 0; i < 8; i++) begin
            if (r[i] && ((i + 7 - m_ptr) % 8) < bestd) begin
                bestd = (i + 7 - m_ptr) % 8;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = w;
        m_sel   = w;
        m_cnt   = 0;
    endtask

    task automatic model_update(input logic [7:0] r, input logic [7:0] l);
        bit v;
        bit to;
        if (m_owner < 0) begin
            if (r != 8'h00) model_grant(pick(r));
        end else begin
            v  = r[m_owner];
            to = TO_EN && v && (m_cnt + 1 == HOLD);
            if (v) m_cnt++;
            if (!v || l[m_owner] || to) begin
                if (r != 8'h00) model_grant(pick(r));
                else m_owner = -1;
            end
        end
    endtask

    task automatic check_outputs();
        bit          ev;
        logic [7:0]  eg;
        logic [31:0] ed;
        ev = (m_owner >= 0) && req[m_owner];
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        ed = ev ? d[m_owner] : 32'h0;
        chk("gnt",       {24'h0, gnt},       {24'h0, eg});
        chk("sel",       {29'h0, sel},       32'(m_sel));
        chk("bus_valid", {31'h0, bus_valid}, {31'h0, ev});
        chk("bus_data",  bus_data,           ed);
        chk("timeout",   {31'h0, timeout},   {31'h0, TO_EN && ev && (m_cnt + 1 == HOLD)});
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance model at edge.
    task automatic step(input logic [7:0] r, input logic [7:0] l);
        req  = r;
        last = l;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update(r, l);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        last  = 8'h00;
        for (int i = 0; i < 8; i++) d[i] = 32'(i) * 32'h11111111;

        // Reset state
        #12;
        check_outputs();
        chk("rst_sel", {29'h0, sel}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, last on third beat, then requester goes quiet
        step(8'h04, 8'h00);
        step(8'h04, 8'h00);
        chk("single_gnt", {24'h0, gnt}, 32'h04);
        step(8'h04, 8'h00);
        step(8'h04, 8'h04);
        step(8'h00, 8'h00);
        step(8'h00, 8'h00);

        // Rotation: everyone requests and ends on its first beat
        for (int i = 0; i < 10; i++) step(8'hFF, 8'hFF);
        step(8'h00, 8'h00);
        step(8'h00, 8'h00);

        // Back-to-back priority: owner 5 finishing while 6 and 0 wait
        pulse_reset();
        step(8'h20, 8'h00);
        step(8'h61, 8'h20);
        chk("b2b_sel6", {29'h0, sel}, 32'd6);
        step(8'h41, 8'h40);
        chk("b2b_sel0", {29'h0, sel}, 32'd0);
        step(8'h01, 8'h01);
        step(8'h00, 8'h00);

        // Request drop: owner 3 lets go while requester 1 waits
        pulse_reset();
        step(8'h08, 8'h00);
        step(8'h0A, 8'h00);
        step(8'h02, 8'h00);
        chk("drop_sel1", {29'h0, sel}, 32'd1);
        step(8'h00, 8'h00);

        // Async reset mid-grant of requester 7
        pulse_reset();
        step(8'h80, 8'h00);
        step(8'h80, 8'h00);
        chk("pre_rst_gnt", {24'h0, gnt}, 32'h80);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt",   {24'h0, gnt},       32'h0);
        chk("arst_valid", {31'h0, bus_valid}, 32'h0);
        chk("arst_data",  bus_data,           32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        step(8'h81, 8'h00);
        chk("post_rst_gnt", {24'h0, gnt}, 32'h01);
        step(8'h81, 8'h01);
        step(8'h00, 8'h00);

`ifdef ARB_TIMEOUT_EN
        // Forced release after HOLD beats with another requester waiting
        pulse_reset();
        step(8'h0C, 8'h00);
        for (int i = 0; i < HOLD; i++) step(8'h0C, 8'h00);
        chk("to_sel3", {29'h0, sel}, 32'd3);
        step(8'h00, 8'h00);
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] r;
            logic [7:0] l;
            for (int i = 0; i < 8; i++) d[i] = $urandom;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            l = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if (n % 500 == 499) pulse_reset();
            step(r, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
